// File: rtl/vme_func_decoder.sv
// vme_func_decoder
// VME64x CR/CSR function decoder. Holds one ADER register per function,
// byte-writable through the CR/CSR space. The module enable bit is reached
// through BIT_SET/BIT_CLR. The decoder classifies each valid_i request as a
// hit on the lowest-index matching function and returns the in-window byte
// offset one cycle later.
// Optional feature: define VME_FUNC_DECODER_HIT_CNT_EN to build per-function
// saturating hit counters. Without it, hit_cnt_o is tied to zero.
module vme_func_decoder #(
  parameter int          g_num_funcs = 2,
  parameter int          g_win_log2  = 19,
  parameter logic [18:0] g_ader_base = 19'h7FF63
) (
  input  logic                       clk_sys_i,
  input  logic                       rst_n_i,
  input  logic                       csr_we_i,
  input  logic                       csr_re_i,
  input  logic [18:0]                csr_addr_i,
  input  logic [7:0]                 csr_data_i,
  output logic [7:0]                 csr_data_o,
  input  logic                       valid_i,
  input  logic [31:0]                addr_i,
  input  logic [5:0]                 am_i,
  output logic                       valid_o,
  output logic [g_num_funcs-1:0]     hit_o,
  output logic [2:0]                 func_o,
  output logic [31:0]                offset_o,
  output logic                       module_en_o,
  output logic [32*g_num_funcs-1:0]  hit_cnt_o
);

  localparam logic [18:0] c_bit_set_addr = 19'h7FFFB;
  localparam logic [18:0] c_bit_clr_addr = 19'h7FFF7;
  // Address bits above the window take part in the compare.
  localparam logic [31:0] c_win_mask = 32'hFFFF_FFFF << g_win_log2;
  // A24 cycles only carry address bits [23:0].
  localparam logic [31:0] c_a24_mask = c_win_mask & 32'h00FF_FFFF;

  logic [31:0]            ader [g_num_funcs];
  logic                   module_en_reg;
  logic                   am_is_a32;
  logic                   am_is_a24;
  logic [g_num_funcs-1:0] match;
  logic [g_num_funcs-1:0] hit_next;
  logic [2:0]             func_next;
  logic [31:0]            offset_next;
  logic                   found;
  logic [7:0]             rd_next;

  logic                   valid_reg;
  logic [g_num_funcs-1:0] hit_reg;
  logic [2:0]             func_reg;
  logic [31:0]            offset_reg;
  logic [7:0]             csr_data_reg;

  // Per-function ADER storage. Byte 3 sits at the lowest address of the group.
  genvar gi;
  generate
    for (gi = 0; gi < g_num_funcs; gi++) begin : g_func
      localparam logic [18:0] c_b3_addr = g_ader_base + 19'(16 * gi);
      localparam logic [18:0] c_b2_addr = c_b3_addr + 19'd4;
      localparam logic [18:0] c_b1_addr = c_b3_addr + 19'd8;
      localparam logic [18:0] c_b0_addr = c_b3_addr + 19'd12;

      logic [31:0] ader_reg;

      // Bytewise ADER write; reset leaves the function disabled through XAM.
      always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          ader_reg <= 32'h0000_0001;
        end else if (csr_we_i) begin
          if (csr_addr_i == c_b3_addr) ader_reg[31:24] <= csr_data_i;
          if (csr_addr_i == c_b2_addr) ader_reg[23:16] <= csr_data_i;
          if (csr_addr_i == c_b1_addr) ader_reg[15:8]  <= csr_data_i;
          if (csr_addr_i == c_b0_addr) ader_reg[7:0]   <= csr_data_i;
        end
      end

      assign ader[gi] = ader_reg;
    end
  endgenerate

  // Module enable: BIT_SET/BIT_CLR act on data bit 4 only.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      module_en_reg <= 1'b0;
    end else if (csr_we_i && csr_data_i[4]) begin
      if (csr_addr_i == c_bit_set_addr) begin
        module_en_reg <= 1'b1;
      end else if (csr_addr_i == c_bit_clr_addr) begin
        module_en_reg <= 1'b0;
      end
    end
  end

  assign module_en_o = module_en_reg;

  // Classify the address modifier into A32, A24 or unsupported.
  always_comb begin
    am_is_a32 = 1'b0;
    am_is_a24 = 1'b0;
    case (am_i)
      6'h09, 6'h0A, 6'h0D, 6'h0E: am_is_a32 = 1'b1;
      6'h39, 6'h3A, 6'h3D, 6'h3E: am_is_a24 = 1'b1;
      default: ;
    endcase
  end

  // Per-function match against the current (pre-write) ADER and enable.
  always_comb begin
    match = '0;
    for (int f = 0; f < g_num_funcs; f++) begin
      if (module_en_reg && !ader[f][0] && (am_i == ader[f][7:2])) begin
        if (am_is_a32 && (((addr_i ^ ader[f]) & c_win_mask) == 32'h0)) begin
          match[f] = 1'b1;
        end
        if (am_is_a24 && (((addr_i ^ ader[f]) & c_a24_mask) == 32'h0)) begin
          match[f] = 1'b1;
        end
      end
    end
  end

  // Lowest-index priority select; a miss reports zero everywhere.
  always_comb begin
    hit_next    = '0;
    func_next   = 3'd0;
    found       = 1'b0;
    offset_next = 32'h0;
    for (int f = 0; f < g_num_funcs; f++) begin
      if (match[f] && !found) begin
        found       = 1'b1;
        hit_next[f] = 1'b1;
        func_next   = 3'(f);
      end
    end
    if (found) begin
      offset_next = addr_i & ~c_win_mask;
    end
  end

  // One-cycle decode pipeline; outputs are zero outside a valid_o pulse.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_reg  <= 1'b0;
      hit_reg    <= '0;
      func_reg   <= 3'd0;
      offset_reg <= 32'h0;
    end else begin
      valid_reg <= valid_i;
      if (valid_i) begin
        hit_reg    <= hit_next;
        func_reg   <= func_next;
        offset_reg <= offset_next;
      end else begin
        hit_reg    <= '0;
        func_reg   <= 3'd0;
        offset_reg <= 32'h0;
      end
    end
  end

  assign valid_o  = valid_reg;
  assign hit_o    = hit_reg;
  assign func_o   = func_reg;
  assign offset_o = offset_reg;

  // CR/CSR read mux built from current register contents, so a read that
  // coincides with a write sees the old value.
  always_comb begin
    rd_next = 8'h00;
    if ((csr_addr_i == c_bit_set_addr) || (csr_addr_i == c_bit_clr_addr)) begin
      rd_next = {3'b000, module_en_reg, 4'b0000};
    end
    for (int f = 0; f < g_num_funcs; f++) begin
      for (int b = 0; b < 4; b++) begin
        if (csr_addr_i == (g_ader_base + 19'(16 * f + 4 * b))) begin
          rd_next = ader[f][8 * (3 - b) +: 8];
        end
      end
    end
  end

  // Registered read data, presented the cycle after csr_re_i.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csr_data_reg <= 8'h00;
    end else if (csr_re_i) begin
      csr_data_reg <= rd_next;
    end else begin
      csr_data_reg <= 8'h00;
    end
  end

  assign csr_data_o = csr_data_reg;

`ifdef VME_FUNC_DECODER_HIT_CNT_EN
  logic module_en_prev;
  logic en_fall;

  // Delayed enable, used to find the falling edge that clears the counters.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      module_en_prev <= 1'b0;
    end else begin
      module_en_prev <= module_en_reg;
    end
  end

  assign en_fall = module_en_prev & ~module_en_reg;

  generate
    for (gi = 0; gi < g_num_funcs; gi++) begin : g_cnt
      logic [31:0] cnt_reg;

      // Count reported hits, saturating; disabling the module clears it.
      always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          cnt_reg <= 32'h0;
        end else if (en_fall) begin
          cnt_reg <= 32'h0;
        end else if (valid_reg && hit_reg[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end

      assign hit_cnt_o[32 * gi +: 32] = cnt_reg;
    end
  endgenerate
`else
  assign hit_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vme_func_decoder.sv
// tb_vme_func_decoder
// Directed scoreboard bench: the driver pushes expected decode results and
// CSR read data into queues, and a monitor compares them against the DUT
// one cycle after the request. The hit-counter check follows
// VME_FUNC_DECODER_HIT_CNT_EN.
module tb_vme_func_decoder;

  localparam int NF = 2;

  localparam logic [18:0] F0_B3 = 19'h7FF63;
  localparam logic [18:0] F0_B2 = 19'h7FF67;
  localparam logic [18:0] F0_B1 = 19'h7FF6B;
  localparam logic [18:0] F0_B0 = 19'h7FF6F;
  localparam logic [18:0] F1_B3 = 19'h7FF73;
  localparam logic [18:0] F1_B2 = 19'h7FF77;
  localparam logic [18:0] F1_B1 = 19'h7FF7B;
  localparam logic [18:0] F1_B0 = 19'h7FF7F;
  localparam logic [18:0] BSET  = 19'h7FFFB;
  localparam logic [18:0] BCLR  = 19'h7FFF7;

  logic              clk_sys_i = 1'b0;
  logic              rst_n_i   = 1'b0;
  logic              csr_we_i  = 1'b0;
  logic              csr_re_i  = 1'b0;
  logic [18:0]       csr_addr_i = '0;
  logic [7:0]        csr_data_i = '0;
  logic [7:0]        csr_data_o;
  logic              valid_i = 1'b0;
  logic [31:0]       addr_i  = '0;
  logic [5:0]        am_i    = '0;
  logic              valid_o;
  logic [NF-1:0]     hit_o;
  logic [2:0]        func_o;
  logic [31:0]       offset_o;
  logic              module_en_o;
  logic [32*NF-1:0]  hit_cnt_o;

  typedef struct {
    logic [NF-1:0] hit;
    logic [2:0]    fn;
    logic [31:0]   off;
  } dec_t;

  dec_t       dec_q[$];
  logic [7:0] rd_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  vme_func_decoder dut (
    .clk_sys_i   (clk_sys_i),
    .rst_n_i     (rst_n_i),
    .csr_we_i    (csr_we_i),
    .csr_re_i    (csr_re_i),
    .csr_addr_i  (csr_addr_i),
    .csr_data_i  (csr_data_i),
    .csr_data_o  (csr_data_o),
    .valid_i     (valid_i),
    .addr_i      (addr_i),
    .am_i        (am_i),
    .valid_o     (valid_o),
    .hit_o       (hit_o),
    .func_o      (func_o),
    .offset_o    (offset_o),
    .module_en_o (module_en_o),
    .hit_cnt_o   (hit_cnt_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Stimulus helpers: set strobes for the coming edge, then step() one cycle.
  task automatic set_wr(input logic [18:0] a, input logic [7:0] d);
    csr_we_i = 1'b1; csr_addr_i = a; csr_data_i = d;
  endtask

  task automatic set_rd(input logic [18:0] a, input logic [7:0] want);
    csr_re_i = 1'b1; csr_addr_i = a; rd_q.push_back(want);
  endtask

  task automatic set_dec(input logic [31:0] a, input logic [5:0] am,
                         input logic [NF-1:0] hit, input logic [2:0] fn,
                         input logic [31:0] off);
    dec_t e;
    valid_i = 1'b1; addr_i = a; am_i = am;
    e.hit = hit; e.fn = fn; e.off = off;
    dec_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk_sys_i);
    csr_we_i = 1'b0; csr_re_i = 1'b0; valid_i = 1'b0;
  endtask

  task automatic wr(input logic [18:0] a, input logic [7:0] d);
    set_wr(a, d); step();
  endtask

  task automatic rd(input logic [18:0] a, input logic [7:0] want);
    set_rd(a, want); step();
  endtask

  task automatic dec(input logic [31:0] a, input logic [5:0] am,
                     input logic [NF-1:0] hit, input logic [2:0] fn,
                     input logic [31:0] off);
    set_dec(a, am, hit, fn, off); step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid_o"},     valid_o,     0);
    chk({tag, " hit_o"},       hit_o,       0);
    chk({tag, " func_o"},      func_o,      0);
    chk({tag, " offset_o"},    offset_o,    0);
    chk({tag, " csr_data_o"},  csr_data_o,  0);
    chk({tag, " module_en_o"}, module_en_o, 0);
    chk({tag, " hit_cnt_o"},   hit_cnt_o,   0);
  endtask

  // Monitor: compares each output transaction with the head of its queue.
  initial begin : monitor
    logic v_seen;
    logic r_seen;
    dec_t e;
    logic [7:0] rwant;
    forever begin
      @(posedge clk_sys_i);
      v_seen = valid_i && rst_n_i;
      r_seen = csr_re_i && rst_n_i;
      #1;
      if (rst_n_i) begin
        if (r_seen) begin
          if (rd_q.size() == 0) begin
            chk("rd_q underflow", 1, 0);
          end else begin
            rwant = rd_q.pop_front();
            chk("csr_data_o", csr_data_o, rwant);
            $display("csr read  data=%02h expected=%02h", csr_data_o, rwant);
          end
        end
        if (v_seen || valid_o) begin
          chk("valid_o", valid_o, v_seen);
          if (v_seen) begin
            if (dec_q.size() == 0) begin
              chk("dec_q underflow", 1, 0);
            end else begin
              e = dec_q.pop_front();
              chk("hit_o", hit_o, e.hit);
              chk("func_o", func_o, e.fn);
              chk("offset_o", offset_o, e.off);
              $display("decode    valid=%0b hit=%b func=%0d offset=%08h expected hit=%b func=%0d offset=%08h",
                       valid_o, hit_o, func_o, offset_o, e.hit, e.fn, e.off);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [31:0] cnt_want;
`ifdef VME_FUNC_DECODER_HIT_CNT_EN
    cnt_want = 32'd3;
`else
    cnt_want = 32'd0;
`endif
    // Reset state
    @(negedge clk_sys_i);
    @(negedge clk_sys_i);
    chk_all_zero("reset");
    rst_n_i = 1'b1;
    step();

    rd(F0_B0, 8'h01);
    rd(F1_B3, 8'h00);
    rd(BSET,  8'h00);
    // Disabled module never hits
    dec(32'h00C4_0008, 6'h39, 2'b00, 3'd0, 32'h0);

    // Func1 = 00C000E4 (A24, AM 0x39), enable module
    wr(F1_B3, 8'h00); wr(F1_B2, 8'hC0); wr(F1_B1, 8'h00); wr(F1_B0, 8'hE4);
    wr(BSET, 8'h10);
    chk("module_en_o set", module_en_o, 1);
    rd(BSET,  8'h10);
    rd(BCLR,  8'h10);
    rd(F1_B0, 8'hE4);
    rd(F1_B2, 8'hC0);

    // Back-to-back decodes: hit, wrong AM, window top, above window, A24 ignores [31:24]
    dec(32'h00C4_0008, 6'h39, 2'b10, 3'd1, 32'h0004_0008);
    dec(32'h00C4_0008, 6'h09, 2'b00, 3'd0, 32'h0);
    dec(32'h00C7_FFFF, 6'h39, 2'b10, 3'd1, 32'h0007_FFFF);
    dec(32'h00C8_0000, 6'h39, 2'b00, 3'd0, 32'h0);
    dec(32'h00BF_FFFF, 6'h39, 2'b00, 3'd0, 32'h0);
    dec(32'hFFC4_0008, 6'h39, 2'b10, 3'd1, 32'h0004_0008);

    // Func0 identical to func1: lowest index wins
    wr(F0_B3, 8'h00); wr(F0_B2, 8'hC0); wr(F0_B1, 8'h00); wr(F0_B0, 8'hE4);
    dec(32'h00C4_0008, 6'h39, 2'b01, 3'd0, 32'h0004_0008);

    // Func0 = 12300024 (A32, AM 0x09)
    wr(F0_B3, 8'h12); wr(F0_B2, 8'h30); wr(F0_B1, 8'h00); wr(F0_B0, 8'h24);
    dec(32'h1237_FFF0, 6'h09, 2'b01, 3'd0, 32'h0007_FFF0);
    dec(32'h1238_0000, 6'h09, 2'b00, 3'd0, 32'h0);
    dec(32'h0237_FFF0, 6'h09, 2'b00, 3'd0, 32'h0);
    dec(32'h1234_0000, 6'h39, 2'b00, 3'd0, 32'h0);
    dec(32'h1230_0000, 6'h3F, 2'b00, 3'd0, 32'h0);

    // Write func1 byte0 (sets XAM) in the same cycle as a decode: old ADER used
    set_wr(F1_B0, 8'hE5);
    set_dec(32'h00C4_0008, 6'h39, 2'b10, 3'd1, 32'h0004_0008);
    step();
    dec(32'h00C4_0008, 6'h39, 2'b00, 3'd0, 32'h0);
    rd(F1_B0, 8'hE5);
    // Simultaneous write and read of the same byte returns the old value
    set_wr(F1_B0, 8'hE4);
    set_rd(F1_B0, 8'hE5);
    step();
    rd(F1_B0, 8'hE4);
    dec(32'h00C4_0008, 6'h39, 2'b10, 3'd1, 32'h0004_0008);

    // Hit counters: clear via BIT_CLR, three hits on func1, clear again
    wr(BCLR, 8'h10);
    chk("module_en_o clr", module_en_o, 0);
    idle(2);
    chk("hit_cnt after clr", hit_cnt_o, 0);
    wr(BSET, 8'h10);
    dec(32'h00C4_0008, 6'h39, 2'b10, 3'd1, 32'h0004_0008);
    dec(32'h00C0_0000, 6'h3D, 2'b00, 3'd0, 32'h0);
    dec(32'h00C0_0000, 6'h39, 2'b10, 3'd1, 32'h0000_0000);
    dec(32'h00C7_0000, 6'h39, 2'b10, 3'd1, 32'h0007_0000);
    idle(2);
    chk("hit_cnt func1", hit_cnt_o[63:32], cnt_want);
    chk("hit_cnt func0", hit_cnt_o[31:0], 0);
    wr(BCLR, 8'h10);
    dec(32'h00C4_0008, 6'h39, 2'b00, 3'd0, 32'h0);
    idle(2);
    chk("hit_cnt cleared", hit_cnt_o[63:32], 0);

    // Reset in the middle of a decode burst
    wr(BSET, 8'h10);
    dec(32'h00C4_0008, 6'h39, 2'b10, 3'd1, 32'h0004_0008);
    dec(32'h1230_0000, 6'h09, 2'b01, 3'd0, 32'h0);
    set_dec(32'h00C4_0010, 6'h39, 2'b10, 3'd1, 32'h0004_0010);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("mid reset");
    dec_q.delete();
    rd_q.delete();
    valid_i = 1'b0;
    @(negedge clk_sys_i);
    @(negedge clk_sys_i);
    rst_n_i = 1'b1;
    idle(3);
    rd(F0_B3, 8'h00);
    rd(F0_B0, 8'h01);
    rd(F1_B2, 8'h00);
    rd(F1_B0, 8'h01);
    rd(BCLR,  8'h00);
    chk("module_en_o after reset", module_en_o, 0);
    dec(32'h00C4_0008, 6'h39, 2'b00, 3'd0, 32'h0);
    idle(3);

    chk("dec_q drained", dec_q.size(), 0);
    chk("rd_q drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
